simon_round_ctrl: RTL and testbench

// - Round sequencer for Simon128/256: runs the 72-round encrypt or decrypt datapath on one 128-bit block.
// - Fetches round keys from the key-schedule memory (mem[0:71]) over a 1-cycle-latency read port.
// - Sits between the top-level start/ctrl/in/out/done interface and the key schedule.
// - Replaces the unfinished dec instance; gated by key_ready (key_done from the key schedule).

---
 rtl/simon_pkg.sv | 27 ++
 rtl/simon_round.sv | 23 ++
 rtl/simon_round_ctrl.sv | 124 ++++++++++++
 tb/tb_simon_round_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - Simon128/256 constants, controller states and round function shared with the key schedule
package simon_pkg;

  localparam int WORD      = 64;
  localparam int ROUNDS    = 72;
  localparam int KEY_ADR_W = 7;

  // z4 sequence (period 62); the key schedule consumes bit (i mod 62)
  localparam logic [63:0] SIMON_Z = 64'h3DC94C3A046D678B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_KEY,
    ST_FETCH,
    ST_RUN,
    ST_FIN
  } state_t;

  function automatic logic [WORD-1:0] simon_f(input logic [WORD-1:0] a);
    logic [WORD-1:0] r1, r2, r8;
    r1 = {a[WORD-2:0], a[WORD-1]};
    r2 = {a[WORD-3:0], a[WORD-1:WORD-2]};
    r8 = {a[WORD-9:0], a[WORD-1:WORD-8]};
    return (r1 & r8) ^ r2;
  endfunction

endpackage

// File: rtl/simon_round.sv
// rtl/simon_round.sv - one combinational Simon round, encrypt or its inverse
module simon_round
  import simon_pkg::*;
(
  input  logic            dir,
  input  logic [WORD-1:0] x,
  input  logic [WORD-1:0] y,
  input  logic [WORD-1:0] key,
  output logic [WORD-1:0] x_nxt,
  output logic [WORD-1:0] y_nxt
);

  always_comb begin
    if (dir) begin
      x_nxt = y;
      y_nxt = x ^ simon_f(y) ^ key;
    end else begin
      x_nxt = y ^ simon_f(x) ^ key;
      y_nxt = x;
    end
  end

endmodule

// File: rtl/simon_round_ctrl.sv
// rtl/simon_round_ctrl.sv - Simon128/256 round sequencer fetching round keys over a 1-cycle read port
module simon_round_ctrl
  import simon_pkg::*;
#(
  parameter int WORD      = simon_pkg::WORD,
  parameter int ROUNDS    = simon_pkg::ROUNDS,
  parameter int KEY_ADR_W = simon_pkg::KEY_ADR_W
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 start,
  input  logic                 ctrl,
  input  logic [2*WORD-1:0]    in,
  input  logic                 key_ready,
  output logic [KEY_ADR_W-1:0] key_adr,
  input  logic [WORD-1:0]      key,
  output logic [2*WORD-1:0]    out,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [KEY_ADR_W-1:0] ADR_LAST = KEY_ADR_W'(ROUNDS - 1);

  state_t               state, state_nxt;
  logic [WORD-1:0]      x_q, y_q, x_nxt, y_nxt;
  logic                 dir_q;
  logic [KEY_ADR_W-1:0] rnd_q;
  logic [KEY_ADR_W-1:0] adr_step;
  logic                 done_nxt, err_nxt;

  simon_round u_round (
    .dir   (dir_q),
    .x     (x_q),
    .y     (y_q),
    .key   (key),
    .x_nxt (x_nxt),
    .y_nxt (y_nxt)
  );

  // Prefetch address runs one round ahead and clamps at the memory ends
  always_comb begin
    adr_step = key_adr;
    if (dir_q) begin
      if (key_adr != '0) adr_step = key_adr - 1'b1;
    end else if (key_adr != ADR_LAST) begin
      adr_step = key_adr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE:     if (start) state_nxt = key_ready ? ST_FETCH : ST_WAIT_KEY;
      ST_WAIT_KEY: if (key_ready) state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (!key_ready) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!key_ready) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
        end else if (rnd_q == ADR_LAST) begin
          state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state   <= ST_IDLE;
      key_adr <= '0;
      out     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rnd_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      dir_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE);
      done  <= done_nxt;
      err   <= err_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            x_q     <= in[2*WORD-1:WORD];
            y_q     <= in[WORD-1:0];
            dir_q   <= ctrl;
            key_adr <= ctrl ? ADR_LAST : '0;
          end
        end
        ST_FETCH: begin
          rnd_q   <= '0;
          key_adr <= adr_step;
        end
        ST_RUN: begin
          x_q     <= x_nxt;
          y_q     <= y_nxt;
          rnd_q   <= rnd_q + 1'b1;
          key_adr <= adr_step;
        end
        ST_FIN: out <= {x_q, y_q};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_round_ctrl.sv
// tb/tb_simon_round_ctrl.sv - self-checking bench for simon_round_ctrl against a Simon128/256 reference model
module tb_simon_round_ctrl;

  logic         clk = 1'b0;
  logic         res_n, start, ctrl, key_ready;
  logic [127:0] in_blk, out_blk;
  logic [6:0]   key_adr;
  logic [63:0]  key;
  logic         busy, done, err;

  int total = 0;
  int bad   = 0;
  int viol  = 0;

  logic [63:0]  mem [0:71];
  logic [63:0]  rk  [0:71];
  logic [127:0] last_out;
  logic         prev_done = 1'b0;
  logic         prev_err  = 1'b0;

  localparam logic [127:0] KAT_PT = 128'h74206e69206d6f6f_6d69732061207369;
  localparam logic [127:0] KAT_CT = 128'h8d2b5579afc8a3a0_3bf72a87efe7b868;

  always #5 clk = ~clk;

  simon_round_ctrl dut (
    .clk       (clk),
    .res_n     (res_n),
    .start     (start),
    .ctrl      (ctrl),
    .in        (in_blk),
    .key_ready (key_ready),
    .key_adr   (key_adr),
    .key       (key),
    .out       (out_blk),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always @(posedge clk) key <= (key_adr <= 7'd71) ? mem[key_adr] : 64'd0;

  always @(negedge clk) begin
    if (res_n && ((key_adr > 7'd71) || (done && err) || ((done || err) && busy) ||
                  (done && prev_done) || (err && prev_err)))
      viol <= viol + 1;
    prev_done <= done;
    prev_err  <= err;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rotl(input logic [63:0] a, input int s);
    return (a << s) | (a >> (64 - s));
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] a, input int s);
    return (a >> s) | (a << (64 - s));
  endfunction

  function automatic logic [63:0] ref_f(input logic [63:0] a);
    return (rotl(a, 1) & rotl(a, 8)) ^ rotl(a, 2);
  endfunction

  task automatic load_key(input logic [255:0] k);
    logic [63:0] zseq, tmp;
    zseq  = 64'h3DC94C3A046D678B;
    rk[0] = k[63:0];
    rk[1] = k[127:64];
    rk[2] = k[191:128];
    rk[3] = k[255:192];
    for (int i = 0; i < 68; i++) begin
      tmp = rotr(rk[i+3], 3) ^ rk[i+1];
      tmp = tmp ^ rotr(tmp, 1);
      rk[i+4] = ~rk[i] ^ tmp ^ {63'd0, zseq[i % 62]} ^ 64'd3;
    end
    for (int i = 0; i < 72; i++) mem[i] = rk[i];
  endtask

  function automatic logic [127:0] ref_enc(input logic [127:0] pt);
    logic [63:0] x, y, t;
    x = pt[127:64];
    y = pt[63:0];
    for (int i = 0; i < 72; i++) begin
      t = x;
      x = y ^ ref_f(x) ^ rk[i];
      y = t;
    end
    return {x, y};
  endfunction

  // Start one block, scramble in/ctrl while busy, and check latency, result, busy and address walk
  task automatic run_block(input string tag, input logic [127:0] blk, input logic dir,
                           input logic [127:0] exp);
    int   n;
    bit   seen, busy_ok, adr_ok, err_seen;
    logic [6:0] exp_adr;
    @(negedge clk);
    start  = 1'b1;
    in_blk = blk;
    ctrl   = dir;
    @(negedge clk);
    start  = 1'b0;
    in_blk = {$urandom, $urandom, $urandom, $urandom};
    ctrl   = ~dir;
    n = 1; seen = 0; busy_ok = 1; adr_ok = 1; err_seen = 0;
    while (!seen && n < 300) begin
      if (done) begin
        seen = 1;
      end else begin
        if (!busy) busy_ok = 0;
        if (err) err_seen = 1;
        exp_adr = dir ? 7'(72 - n) : 7'(n - 1);
        if (n <= 72 && key_adr != exp_adr) adr_ok = 0;
        @(negedge clk);
        n++;
      end
    end
    chk({tag, "_latency"}, n, 75);
    chk({tag, "_out"}, out_blk, exp);
    chk({tag, "_busy_run"}, busy_ok, 1);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_key_adr_walk"}, adr_ok, 1);
    chk({tag, "_no_err"}, err_seen, 0);
    last_out = exp;
  endtask

  initial begin
    logic [255:0] rkey;
    logic [127:0] pt, ct;
    int           n, m;
    bit           seen, busy_ok, flag;

    res_n = 1'b0; start = 1'b0; ctrl = 1'b0; key_ready = 1'b1; in_blk = '0;
    last_out = '0;
    load_key({64'h1f1e1d1c1b1a1918, 64'h1716151413121110,
              64'h0f0e0d0c0b0a0908, 64'h0706050403020100});
    repeat (3) @(negedge clk);
    chk("rst_out", out_blk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_key_adr", key_adr, 0);
    res_n = 1'b1;

    run_block("kat_enc", KAT_PT, 1'b0, KAT_CT);
    run_block("kat_dec", KAT_CT, 1'b1, KAT_PT);

    // key_ready low at start, raised 10 cycles later; extra start pulses must be ignored
    key_ready = 1'b0;
    @(negedge clk);
    start = 1'b1; in_blk = KAT_PT; ctrl = 1'b0;
    busy_ok = 1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (!busy) busy_ok = 0;
      start  = i[0];
      in_blk = {$urandom, $urandom, $urandom, $urandom};
      ctrl   = 1'b1;
    end
    key_ready = 1'b1;
    m = 0; seen = 0;
    while (!seen && m < 300) begin
      @(negedge clk);
      m++;
      if (done) begin
        seen  = 1;
        start = 1'b0;
      end else begin
        if (!busy) busy_ok = 0;
        start = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    chk("wait_latency", m, 75);
    chk("wait_out", out_blk, KAT_CT);
    chk("wait_busy_held", busy_ok, 1);
    last_out = KAT_CT;

    // key_ready drops in round 30
    @(negedge clk);
    start = 1'b1; in_blk = 128'h0123456789abcdef_fedcba9876543210; ctrl = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 1; flag = 0;
    while (n < 32) begin
      if (done || err) flag = 1;
      @(negedge clk);
      n++;
    end
    key_ready = 1'b0;
    @(negedge clk);
    chk("abort_pre_pulse", flag, 0);
    chk("abort_err", err, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_out_kept", out_blk, last_out);
    key_ready = 1'b1;
    flag = 0;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      if (done || err || busy) flag = 1;
    end
    chk("abort_quiet_after", flag, 0);
    run_block("after_abort", KAT_PT, 1'b0, KAT_CT);

    // asynchronous reset in round 40
    @(negedge clk);
    start = 1'b1; in_blk = KAT_CT; ctrl = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (41) @(negedge clk);
    res_n = 1'b0;
    #1;
    chk("mid_rst_out", out_blk, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_key_adr", key_adr, 0);
    @(negedge clk);
    res_n = 1'b1;
    run_block("after_rst", KAT_PT, 1'b0, KAT_CT);

    for (int r = 0; r < 200; r++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pt   = {$urandom, $urandom, $urandom, $urandom};
      load_key(rkey);
      ct = ref_enc(pt);
      run_block("rnd_enc", pt, 1'b0, ct);
      run_block("rnd_dec", ct, 1'b1, pt);
    end

    repeat (2) @(negedge clk);
    chk("props", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
